charmap_video: RTL and testbench

CHARMAP_VIDEO -- requirements
Module: charmap_video

---
 rtl/charmap_video.sv | 165 ++++++++++++++++
 tb/tb_charmap_video.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/charmap_video.sv
`default_nettype none
// ============================================================================
// Module : charmap_video
// Text-mode renderer with three ce_pix pipeline stages: map fetch, font fetch, pixel select.
// Rev    : 1.0 - initial release
// ============================================================================
module charmap_video #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 11
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [8:0]        hcnt,
  input  logic [8:0]        vcnt,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              reg_wr,
  input  logic [1:0]        reg_addr,
  input  logic [7:0]        reg_din,
  output logic [ADDR_W-1:0] chram_addr,
  input  logic [7:0]        chram_q,
  input  logic [7:0]        fgcol_q,
  input  logic [7:0]        bgcol_q,
  output logic [10:0]       chrom_addr,
  input  logic [7:0]        chrom_q,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_de,
  output logic [7:0]        frame_cnt
);

  localparam logic [1:0] c_REG_SCROLL_X = 2'd0;
  localparam logic [1:0] c_REG_SCROLL_Y = 2'd1;
  localparam logic [1:0] c_REG_CONTROL  = 2'd2;
  localparam logic [1:0] c_REG_BORDER   = 2'd3;
  localparam logic [9:0] c_PIX_W        = 10'(COLS * 8);
  localparam logic [9:0] c_PIX_H        = 10'(ROWS * 8);

  logic [7:0] r_scroll_x, r_scroll_y, r_shadow_x, r_shadow_y;
  logic [1:0] r_control;
  logic [7:0] r_border;
  logic       r_vblank_d;
  logic [7:0] r_frame_cnt;
  logic       w_vb_rise;
  logic       w_latch_mode;

  assign w_vb_rise    = ce_pix & vblank & ~r_vblank_d;
  assign w_latch_mode = r_control[1];

  // Writes land after the vblank copy, so a coincident write stays in the shadow.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_scroll_x  <= 8'd0;
      r_scroll_y  <= 8'd0;
      r_shadow_x  <= 8'd0;
      r_shadow_y  <= 8'd0;
      r_control   <= 2'd0;
      r_border    <= 8'd0;
      r_vblank_d  <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (ce_pix) r_vblank_d <= vblank;
      if (w_vb_rise) begin
        r_scroll_x  <= r_shadow_x;
        r_scroll_y  <= r_shadow_y;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (reg_wr) begin
        case (reg_addr)
          c_REG_SCROLL_X: begin
            r_shadow_x <= reg_din;
            if (!w_latch_mode) r_scroll_x <= reg_din;
          end
          c_REG_SCROLL_Y: begin
            r_shadow_y <= reg_din;
            if (!w_latch_mode) r_scroll_y <= reg_din;
          end
          c_REG_CONTROL: r_control <= reg_din[1:0];
          c_REG_BORDER:  r_border  <= reg_din;
        endcase
      end
    end
  end

  logic [9:0]        w_hsum, w_vsum, w_ex, w_ey;
  logic [ADDR_W-1:0] w_map_addr;

  assign w_hsum     = {1'b0, hcnt} + {2'b00, r_scroll_x};
  assign w_vsum     = {1'b0, vcnt} + {2'b00, r_scroll_y};
  assign w_ex       = w_hsum % c_PIX_W;
  assign w_ey       = w_vsum % c_PIX_H;
  assign w_map_addr = ADDR_W'(w_ey[9:3]) * ADDR_W'(COLS) + ADDR_W'(w_ex[9:3]);

  logic [ADDR_W-1:0] r_chram_addr;
  logic [2:0]        r_ex1, r_ey1, r_ex2;
  logic              r_blank1, r_blank2, r_valid1, r_valid2;
  logic [10:0]       r_chrom_addr;
  logic [7:0]        r_fg2, r_bg2;
  logic [7:0]        r_vga_r, r_vga_g, r_vga_b;
  logic              r_vga_de;
  logic              w_pix;
  logic [7:0]        w_colour;

  assign w_pix    = chrom_q[3'd7 - r_ex2];
  assign w_colour = r_control[0] ? (w_pix ? r_fg2 : r_bg2) : r_border;

  // Valid bits keep the first outputs after reset dark until real data arrives.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_chram_addr <= '0;
      r_ex1        <= 3'd0;
      r_ey1        <= 3'd0;
      r_blank1     <= 1'b0;
      r_valid1     <= 1'b0;
      r_chrom_addr <= 11'd0;
      r_fg2        <= 8'd0;
      r_bg2        <= 8'd0;
      r_ex2        <= 3'd0;
      r_blank2     <= 1'b0;
      r_valid2     <= 1'b0;
      r_vga_r      <= 8'd0;
      r_vga_g      <= 8'd0;
      r_vga_b      <= 8'd0;
      r_vga_de     <= 1'b0;
    end else if (ce_pix) begin
      r_chram_addr <= w_map_addr;
      r_ex1        <= w_ex[2:0];
      r_ey1        <= w_ey[2:0];
      r_blank1     <= hblank | vblank;
      r_valid1     <= 1'b1;

      r_chrom_addr <= {chram_q, r_ey1};
      r_fg2        <= fgcol_q;
      r_bg2        <= bgcol_q;
      r_ex2        <= r_ex1;
      r_blank2     <= r_blank1;
      r_valid2     <= r_valid1;

      if (r_valid2 && !r_blank2) begin
        r_vga_r  <= {w_colour[7:5], w_colour[7:5], 2'b00};
        r_vga_g  <= {w_colour[4:2], w_colour[4:2], 2'b00};
        r_vga_b  <= {w_colour[1:0], w_colour[1:0], w_colour[1:0], 2'b00};
        r_vga_de <= 1'b1;
      end else begin
        r_vga_r  <= 8'd0;
        r_vga_g  <= 8'd0;
        r_vga_b  <= 8'd0;
        r_vga_de <= 1'b0;
      end
    end
  end

  assign chram_addr = r_chram_addr;
  assign chrom_addr = r_chrom_addr;
  assign vga_r      = r_vga_r;
  assign vga_g      = r_vga_g;
  assign vga_b      = r_vga_b;
  assign vga_de     = r_vga_de;
  assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_charmap_video.sv
`default_nettype none
// ============================================================================
// Module : tb_charmap_video
// Self-checking bench for charmap_video against a plain-arithmetic screen model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_charmap_video;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 11;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b1;
  logic              ce_pix = 1'b0;
  logic [8:0]        hcnt = '0, vcnt = '0;
  logic              hblank = 1'b0, vblank = 1'b0;
  logic              reg_wr = 1'b0;
  logic [1:0]        reg_addr = '0;
  logic [7:0]        reg_din = '0;
  logic [ADDR_W-1:0] chram_addr;
  logic [7:0]        chram_q, fgcol_q, bgcol_q, chrom_q;
  logic [10:0]       chrom_addr;
  logic [7:0]        vga_r, vga_g, vga_b, frame_cnt;
  logic              vga_de;

  always #5 clk_sys = ~clk_sys;

  charmap_video #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din),
    .chram_addr(chram_addr), .chram_q(chram_q), .fgcol_q(fgcol_q), .bgcol_q(bgcol_q),
    .chrom_addr(chrom_addr), .chrom_q(chrom_q),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_de(vga_de), .frame_cnt(frame_cnt)
  );

  // Synchronous RAM/ROM models: data one clk_sys after address.
  logic [7:0] chram_mem [0:2047];
  logic [7:0] fg_mem    [0:2047];
  logic [7:0] bg_mem    [0:2047];
  logic [7:0] font_mem  [0:2047];

  always @(posedge clk_sys) begin
    chram_q <= chram_mem[chram_addr];
    fgcol_q <= fg_mem[chram_addr];
    bgcol_q <= bg_mem[chram_addr];
    chrom_q <= font_mem[chrom_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  int m_sx, m_sy, m_shx, m_shy, m_ctrl, m_border, m_frames;
  bit m_prev_vb;
  int exp_addr;
  logic [24:0] exp_q[$];

  function automatic int model_addr(int h, int v);
    int ex, ey;
    ex = (h + m_sx) % (COLS * 8);
    ey = (v + m_sy) % (ROWS * 8);
    return (ey / 8) * COLS + ex / 8;
  endfunction

  // Returns {de, r, g, b} for one raster position.
  function automatic logic [24:0] model_pix(int h, int v, bit blank);
    int ex, ey, addr, code, row, pix, col, r3, g3, b2;
    if (blank) return 25'd0;
    ex   = (h + m_sx) % (COLS * 8);
    ey   = (v + m_sy) % (ROWS * 8);
    addr = (ey / 8) * COLS + ex / 8;
    code = chram_mem[addr];
    row  = font_mem[code * 8 + ey % 8];
    pix  = (row >> (7 - ex % 8)) & 1;
    if (m_ctrl % 2 == 1) col = pix ? int'(fg_mem[addr]) : int'(bg_mem[addr]);
    else                 col = m_border;
    r3 = col / 32;
    g3 = (col / 4) % 8;
    b2 = col % 4;
    return {1'b1, 8'(r3 * 36), 8'(g3 * 36), 8'(b2 * 84)};
  endfunction

  function automatic void model_write(int a, int d);
    case (a)
      0: begin m_shx = d; if ((m_ctrl & 2) == 0) m_sx = d; end
      1: begin m_shy = d; if ((m_ctrl & 2) == 0) m_sy = d; end
      2: m_ctrl = d;
      default: m_border = d;
    endcase
  endfunction

  function automatic void model_reset();
    m_sx = 0; m_sy = 0; m_shx = 0; m_shy = 0;
    m_ctrl = 0; m_border = 0; m_frames = 0; m_prev_vb = 1'b0;
    exp_q.delete();
  endfunction

  task automatic write_reg(input int a, input int d);
    @(negedge clk_sys);
    ce_pix = 1'b0; reg_wr = 1'b1; reg_addr = 2'(a); reg_din = 8'(d);
    @(posedge clk_sys); #1;
    reg_wr = 1'b0;
    model_write(a, d);
  endtask

  // One pixel: a ce_pix edge followed by an idle clk_sys edge; returns #1 past the idle edge.
  task automatic step(input int h, input int v, input bit hb, input bit vb,
                      input bit wr = 1'b0, input int a = 0, input int d = 0);
    @(negedge clk_sys);
    ce_pix = 1'b1; hcnt = 9'(h); vcnt = 9'(v); hblank = hb; vblank = vb;
    reg_wr = wr; reg_addr = 2'(a); reg_din = 8'(d);
    exp_addr = model_addr(h, v);
    exp_q.push_back(model_pix(h, v, hb | vb));
    if (exp_q.size() > 3) void'(exp_q.pop_front());
    @(posedge clk_sys); #1;
    ce_pix = 1'b0; reg_wr = 1'b0;
    if (vb && !m_prev_vb) begin
      m_sx = m_shx; m_sy = m_shy; m_frames = (m_frames + 1) % 256;
    end
    m_prev_vb = vb;
    if (wr) model_write(a, d);
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    n_cmp++; if (chram_addr !== '0) begin n_fail++; $display("FAIL reset_chram_addr got %h exp 0", chram_addr); end
    n_cmp++; if (chrom_addr !== '0) begin n_fail++; $display("FAIL reset_chrom_addr got %h exp 0", chrom_addr); end
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== 25'd0) begin n_fail++; $display("FAIL reset_video got %h exp 0", {vga_de, vga_r, vga_g, vga_b}); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt got %h exp 0", frame_cnt); end
    @(negedge clk_sys) reset_n = 1'b1;
  endtask

  task automatic test_basic_glyph();
    write_reg(2, 1); write_reg(0, 0); write_reg(1, 0);
    chram_mem[0] = 8'h41; fg_mem[0] = 8'hFF; bg_mem[0] = 8'h00; font_mem[16'h41 * 8] = 8'h80;
    exp_q.delete();
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(2, 0, 0, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFCFCFC}) begin n_fail++; $display("FAIL glyph_on got %h exp %h", {vga_de, vga_r, vga_g, vga_b}, {1'b1, 24'hFCFCFC}); end
    step(3, 0, 0, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'h000000}) begin n_fail++; $display("FAIL glyph_off got %h exp %h", {vga_de, vga_r, vga_g, vga_b}, {1'b1, 24'h000000}); end
  endtask

  task automatic test_scroll_wrap();
    write_reg(0, 8);
    step(0, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'd1) begin n_fail++; $display("FAIL scroll_x_addr got %0d exp 1", chram_addr); end
    step(COLS * 8 - 8, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'd0) begin n_fail++; $display("FAIL wrap_x_addr got %0d exp 0", chram_addr); end
    write_reg(0, 0); write_reg(1, 8);
    step(0, ROWS * 8 - 8, 0, 0);
    n_cmp++; if (chram_addr !== 11'd0) begin n_fail++; $display("FAIL wrap_y_addr got %0d exp 0", chram_addr); end
    step(0, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'(COLS)) begin n_fail++; $display("FAIL scroll_y_addr got %0d exp %0d", chram_addr, COLS); end
    write_reg(1, 0);
  endtask

  task automatic test_vblank_latch();
    int f0;
    write_reg(0, 0); write_reg(2, 3); write_reg(0, 16);
    step(0, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'd0) begin n_fail++; $display("FAIL latch_hold got %0d exp 0", chram_addr); end
    f0 = m_frames;
    step(0, 0, 0, 1);
    n_cmp++; if (frame_cnt !== 8'((f0 + 1) % 256)) begin n_fail++; $display("FAIL latch_frame_inc got %0d exp %0d", frame_cnt, (f0 + 1) % 256); end
    step(0, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'd2) begin n_fail++; $display("FAIL latch_copy got %0d exp 2", chram_addr); end
    step(0, 0, 0, 1, 1'b1, 0, 24);
    step(0, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'd2) begin n_fail++; $display("FAIL latch_coincident got %0d exp 2", chram_addr); end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_cmp++; if (chram_addr !== 11'd3) begin n_fail++; $display("FAIL latch_next_rise got %0d exp 3", chram_addr); end
    n_cmp++; if (frame_cnt !== 8'(m_frames)) begin n_fail++; $display("FAIL latch_frame_cnt got %0d exp %0d", frame_cnt, m_frames); end
    write_reg(2, 1); write_reg(0, 0);
  endtask

  task automatic test_frame_wrap();
    for (int i = 0; i < 300 && m_frames != 255; i++) begin
      step(0, 0, 0, 0); step(0, 0, 0, 1);
    end
    n_cmp++; if (frame_cnt !== 8'd255) begin n_fail++; $display("FAIL frame_255 got %0d exp 255", frame_cnt); end
    step(0, 0, 0, 0); step(0, 0, 0, 1);
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL frame_wrap got %0d exp 0", frame_cnt); end
  endtask

  task automatic test_border();
    write_reg(2, 0); write_reg(3, 8'hE0);
    exp_q.delete();
    step(5, 5, 0, 0); step(6, 5, 0, 0); step(7, 5, 1, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFC0000}) begin n_fail++; $display("FAIL border_active got %h exp %h", {vga_de, vga_r, vga_g, vga_b}, {1'b1, 24'hFC0000}); end
    step(8, 5, 1, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFC0000}) begin n_fail++; $display("FAIL border_active2 got %h exp %h", {vga_de, vga_r, vga_g, vga_b}, {1'b1, 24'hFC0000}); end
    step(9, 5, 1, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== 25'd0) begin n_fail++; $display("FAIL border_hblank got %h exp 0", {vga_de, vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_random();
    for (int rnd = 0; rnd < 4; rnd++) begin
      write_reg(2, (rnd == 3) ? 0 : 1);
      write_reg(0, $urandom_range(0, 255));
      write_reg(1, $urandom_range(0, 255));
      write_reg(3, $urandom_range(0, 255));
      exp_q.delete();
      for (int k = 0; k < 150; k++) begin
        step($urandom_range(0, 511), $urandom_range(0, 511),
             $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        n_cmp++; if (chram_addr !== 11'(exp_addr)) begin n_fail++; $display("FAIL rand_addr r%0d k%0d got %0d exp %0d", rnd, k, chram_addr, exp_addr); end
        if (exp_q.size() == 3) begin
          n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== exp_q[0]) begin n_fail++; $display("FAIL rand_pix r%0d k%0d got %h exp %h", rnd, k, {vga_de, vga_r, vga_g, vga_b}, exp_q[0]); end
        end
      end
      n_cmp++; if (frame_cnt !== 8'(m_frames)) begin n_fail++; $display("FAIL rand_frames r%0d got %0d exp %0d", rnd, frame_cnt, m_frames); end
    end
  endtask

  task automatic test_reset_midline();
    write_reg(2, 1);
    for (int k = 0; k < 5; k++) step(20 + k, 40, 0, 0);
    @(posedge clk_sys); #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({chram_addr, chrom_addr, vga_de, vga_r, vga_g, vga_b, frame_cnt} !== '0) begin n_fail++; $display("FAIL midline_reset got %h/%h/%h exp 0", chram_addr, chrom_addr, {vga_de, vga_r, vga_g, vga_b}); end
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
    step(10, 10, 0, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== 25'd0) begin n_fail++; $display("FAIL post_reset_1 got %h exp 0", {vga_de, vga_r, vga_g, vga_b}); end
    step(11, 10, 0, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== 25'd0) begin n_fail++; $display("FAIL post_reset_2 got %h exp 0", {vga_de, vga_r, vga_g, vga_b}); end
    step(12, 10, 0, 0);
    n_cmp++; if ({vga_de, vga_r, vga_g, vga_b} !== exp_q[0] || vga_de !== 1'b1) begin n_fail++; $display("FAIL post_reset_3 got %h exp %h", {vga_de, vga_r, vga_g, vga_b}, exp_q[0]); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL post_reset_frames got %0d exp 0", frame_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      chram_mem[i] = 8'($urandom); fg_mem[i] = 8'($urandom);
      bg_mem[i]    = 8'($urandom); font_mem[i] = 8'($urandom);
    end
    test_reset();
    test_basic_glyph();
    test_scroll_wrap();
    test_vblank_latch();
    test_frame_wrap();
    test_border();
    test_random();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
